snitch_icache_data_ctrl: RTL and testbench

- Initiator-side controller for the single-port instruction-cache data SRAM macro (1-cycle read latency, full-line writes).
- Arbitrates between refill line writes and lookup line reads onto the one SRAM port.
- Tracks the in-flight read and returns read data with its tag over a valid/ready response channel that supports backpressure.
- Sits between the lookup/refill stages and the data SRAM wrapper.

---
 rtl/snitch_icache_data_ctrl.sv | 147 ++++++++++++++
 tb/tb_snitch_icache_data_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/snitch_icache_data_ctrl.sv
// Instruction-cache data SRAM controller: arbitrates refill line writes against lookup
// line reads on the single SRAM port and returns read data over a valid/ready channel
// with a 2-entry response FIFO. Writes have priority, bounded by MAX_WR_STREAK.
// Optional: define SNITCH_ICACHE_DATA_CTRL_BYPASS_EN to serve a same-cycle, same-address
// read directly from the write data instead of stalling it.
module snitch_icache_data_ctrl #(
    parameter int unsigned LINE_WIDTH    = 128,
    parameter int unsigned WAY_COUNT     = 4,
    parameter int unsigned LINE_COUNT    = 128,
    parameter int unsigned ID_WIDTH      = 4,
    parameter int unsigned MAX_WR_STREAK = 4,
    parameter int unsigned ADDR_WIDTH    = $clog2(WAY_COUNT) + $clog2(LINE_COUNT)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  rd_req_valid_i,
    output logic                  rd_req_ready_o,
    input  logic [ADDR_WIDTH-1:0] rd_req_addr_i,
    input  logic [ID_WIDTH-1:0]   rd_req_id_i,
    output logic                  rd_rsp_valid_o,
    input  logic                  rd_rsp_ready_i,
    output logic [LINE_WIDTH-1:0] rd_rsp_data_o,
    output logic [ID_WIDTH-1:0]   rd_rsp_id_o,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [LINE_WIDTH-1:0] wr_data_i,
    output logic                  sram_req_o,
    output logic                  sram_write_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [LINE_WIDTH-1:0] sram_wdata_o,
    input  logic [LINE_WIDTH-1:0] sram_rdata_i
);

    localparam logic [3:0] MAX_STREAK = 4'(MAX_WR_STREAK);

    logic [1:0]            cnt_q, cnt_d;
    logic                  rd_ptr_q, wr_ptr_q;
    logic [LINE_WIDTH-1:0] fifo_data_q [2];
    logic [ID_WIDTH-1:0]   fifo_id_q   [2];
    logic                  inflight_q, byp_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [LINE_WIDTH-1:0] byp_data_q;
    logic [3:0]            streak_q, streak_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;

    logic                  pop, pop_fifo, push;
    logic [2:0]            occ;
    logic                  read_ok, rd_wait, hazard, streak_full;
    logic                  wr_gnt, rd_gnt, byp;
    logic [LINE_WIDTH-1:0] new_data;

    // Credit check, arbitration and SRAM port drive. Grants are masked during reset so all
    // outputs drop to zero as soon as rst_ni falls.
    always_comb begin
        pop         = rd_rsp_valid_o & rd_rsp_ready_i;
        occ         = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
        read_ok     = occ < 3'd2;
        rd_wait     = rd_req_valid_i & read_ok;
        hazard      = wr_valid_i & rd_req_valid_i & (wr_addr_i == rd_req_addr_i);
        streak_full = (streak_q == MAX_STREAK);
`ifdef SNITCH_ICACHE_DATA_CTRL_BYPASS_EN
        byp         = rst_ni & hazard & read_ok;
`else
        byp         = 1'b0;
`endif
        // A same-address write always wins; the read then stalls or is bypassed.
        wr_gnt = rst_ni & wr_valid_i & (hazard | ~(rd_wait & streak_full));
        rd_gnt = rst_ni & rd_wait & ~wr_gnt;

        wr_ready_o     = wr_gnt;
        rd_req_ready_o = rd_gnt | byp;

        sram_req_o   = wr_gnt | rd_gnt;
        sram_write_o = wr_gnt;
        sram_addr_o  = wr_gnt ? wr_addr_i : (rd_gnt ? rd_req_addr_i : addr_q);
        sram_wdata_o = wr_gnt ? wr_data_i : wdata_q;
    end

    // Streak counter: counts writes that overtook a waiting read, saturating at the limit.
    always_comb begin
        streak_d = streak_q;
        if (rd_gnt || byp || !rd_wait) begin
            streak_d = 4'd0;
        end else if (wr_gnt && !streak_full) begin
            streak_d = streak_q + 4'd1;
        end
    end

    // Response selection: FIFO head first, else fall-through of the in-flight read.
    always_comb begin
        new_data       = byp_q ? byp_data_q : sram_rdata_i;
        rd_rsp_valid_o = 1'b0;
        rd_rsp_data_o  = '0;
        rd_rsp_id_o    = '0;
        if (cnt_q != 2'd0) begin
            rd_rsp_valid_o = 1'b1;
            rd_rsp_data_o  = fifo_data_q[rd_ptr_q];
            rd_rsp_id_o    = fifo_id_q[rd_ptr_q];
        end else if (inflight_q) begin
            rd_rsp_valid_o = 1'b1;
            rd_rsp_data_o  = new_data;
            rd_rsp_id_o    = id_q;
        end
        pop_fifo = pop & (cnt_q != 2'd0);
        // The returning line is buffered unless it falls straight through and is taken.
        push     = inflight_q & ~((cnt_q == 2'd0) & rd_rsp_ready_i);
        cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop_fifo};
    end

    // Control state: credits, in-flight tracking, streak and last SRAM address/data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            inflight_q <= 1'b0;
            byp_q      <= 1'b0;
            id_q       <= '0;
            byp_data_q <= '0;
            streak_q   <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            cnt_q      <= cnt_d;
            inflight_q <= rd_gnt | byp;
            byp_q      <= byp;
            streak_q   <= streak_d;
            if (push)               wr_ptr_q   <= ~wr_ptr_q;
            if (pop_fifo)           rd_ptr_q   <= ~rd_ptr_q;
            if (rd_gnt || byp)      id_q       <= rd_req_id_i;
            if (byp)                byp_data_q <= wr_data_i;
            if (sram_req_o)         addr_q     <= sram_addr_o;
            if (wr_gnt)             wdata_q    <= wr_data_i;
        end
    end

    // FIFO storage; validity is tracked by cnt_q, so the payload needs no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= new_data;
            fifo_id_q[wr_ptr_q]   <= id_q;
        end
    end

endmodule

// File: tb/tb_snitch_icache_data_ctrl.sv
// Directed bench for snitch_icache_data_ctrl with a behavioural 1-cycle SRAM.
// Honours SNITCH_ICACHE_DATA_CTRL_BYPASS_EN for the same-address hazard case.
module tb_snitch_icache_data_ctrl;

    localparam int AW = 9;
    localparam int LW = 128;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          rd_req_valid = 1'b0;
    logic          rd_req_ready;
    logic [AW-1:0] rd_req_addr = '0;
    logic [IW-1:0] rd_req_id = '0;
    logic          rd_rsp_valid;
    logic          rd_rsp_ready = 1'b1;
    logic [LW-1:0] rd_rsp_data;
    logic [IW-1:0] rd_rsp_id;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [LW-1:0] wr_data = '0;
    logic          sram_req;
    logic          sram_write;
    logic [AW-1:0] sram_addr;
    logic [LW-1:0] sram_wdata;
    logic [LW-1:0] sram_rdata = '0;

    logic [LW-1:0] mem [512];

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    snitch_icache_data_ctrl dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .rd_req_valid_i (rd_req_valid),
        .rd_req_ready_o (rd_req_ready),
        .rd_req_addr_i  (rd_req_addr),
        .rd_req_id_i    (rd_req_id),
        .rd_rsp_valid_o (rd_rsp_valid),
        .rd_rsp_ready_i (rd_rsp_ready),
        .rd_rsp_data_o  (rd_rsp_data),
        .rd_rsp_id_o    (rd_rsp_id),
        .wr_valid_i     (wr_valid),
        .wr_ready_o     (wr_ready),
        .wr_addr_i      (wr_addr),
        .wr_data_i      (wr_data),
        .sram_req_o     (sram_req),
        .sram_write_o   (sram_write),
        .sram_addr_o    (sram_addr),
        .sram_wdata_o   (sram_wdata),
        .sram_rdata_i   (sram_rdata)
    );

    // Behavioural SRAM macro: write or read, read data one cycle later.
    always @(posedge clk) begin
        if (sram_req) begin
            if (sram_write) mem[sram_addr] <= sram_wdata;
            else            sram_rdata     <= mem[sram_addr];
        end
    end

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic v, input logic [AW-1:0] a, input logic [IW-1:0] id);
        rd_req_valid = v;
        rd_req_addr  = a;
        rd_req_id    = id;
    endtask

    // Expected grant pattern for the streak test (1 = write), oldest cycle in bit 0.
    logic [9:0] streak_exp;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = {4{32'hC0DE0000 | 32'(i)}};

        // Reset: readies stay low even with valids asserted.
        set_rd(1'b1, 9'h005, 4'd3);
        wr_valid = 1'b1;
        #3;
        check("rst_rd_ready", 128'(rd_req_ready), 128'd0);
        check("rst_wr_ready", 128'(wr_ready), 128'd0);
        check("rst_rsp_valid", 128'(rd_rsp_valid), 128'd0);
        check("rst_sram_req", 128'(sram_req), 128'd0);
        check("rst_sram_addr", 128'(sram_addr), 128'd0);
        check("rst_sram_wdata", sram_wdata, 128'd0);
        wr_valid = 1'b0;
        tick();
        rst_ni = 1'b1;

        // Basic read of 0x05, id 3.
        #1;
        check("rd_gnt", 128'(rd_req_ready), 128'd1);
        check("rd_sram_req", 128'(sram_req), 128'd1);
        check("rd_sram_wr", 128'(sram_write), 128'd0);
        check("rd_sram_addr", 128'(sram_addr), 128'h005);
        tick();
        set_rd(1'b0, 9'h000, 4'd0);
        #1;
        check("rsp_valid", 128'(rd_rsp_valid), 128'd1);
        check("rsp_data", rd_rsp_data, {4{32'hC0DE0005}});
        check("rsp_id", 128'(rd_rsp_id), 128'd3);
        tick();

        // Write 0x1F then read it back.
        wr_valid = 1'b1; wr_addr = 9'h01F; wr_data = {16{8'hA5}};
        #1;
        check("wr_ready", 128'(wr_ready), 128'd1);
        check("wr_sram_write", 128'(sram_write), 128'd1);
        tick();
        wr_valid = 1'b0;
        set_rd(1'b1, 9'h01F, 4'd7);
        #1;
        check("idle_wdata_hold", sram_wdata, {16{8'hA5}});
        tick();
        set_rd(1'b0, 9'h000, 4'd0);
        #1;
        check("rbw_data", rd_rsp_data, {16{8'hA5}});
        check("rbw_id", 128'(rd_rsp_id), 128'd7);
        tick();
        #1;
        check("idle_rsp_valid", 128'(rd_rsp_valid), 128'd0);

        // Backpressure: two credits only, order and stability.
        rd_rsp_ready = 1'b0;
        set_rd(1'b1, 9'h001, 4'd1);
        #1;
        check("bp_a_gnt", 128'(rd_req_ready), 128'd1);
        tick();
        set_rd(1'b1, 9'h002, 4'd2);
        #1;
        check("bp_b_gnt", 128'(rd_req_ready), 128'd1);
        check("bp_b_id", 128'(rd_rsp_id), 128'd1);
        tick();
        set_rd(1'b1, 9'h003, 4'd3);
        #1;
        check("bp_c_stall", 128'(rd_req_ready), 128'd0);
        check("bp_c_id", 128'(rd_rsp_id), 128'd1);
        tick();
        #1;
        check("bp_d_stall", 128'(rd_req_ready), 128'd0);
        check("bp_d_data", rd_rsp_data, {4{32'hC0DE0001}});
        tick();
        rd_rsp_ready = 1'b1;
        #1;
        check("bp_e_gnt", 128'(rd_req_ready), 128'd1);
        check("bp_e_id", 128'(rd_rsp_id), 128'd1);
        tick();
        set_rd(1'b0, 9'h000, 4'd0);
        #1;
        check("bp_f_id", 128'(rd_rsp_id), 128'd2);
        check("bp_f_data", rd_rsp_data, {4{32'hC0DE0002}});
        tick();
        #1;
        check("bp_g_id", 128'(rd_rsp_id), 128'd3);
        check("bp_g_data", rd_rsp_data, {4{32'hC0DE0003}});
        tick();
        #1;
        check("bp_h_valid", 128'(rd_rsp_valid), 128'd0);

        // Write streak fairness: W,W,W,W,R repeating.
        streak_exp = 10'b0111101111;
        wr_valid = 1'b1; wr_addr = 9'h100; wr_data = {8{16'h1234}};
        set_rd(1'b1, 9'h002, 4'd9);
        for (int c = 0; c < 10; c++) begin
            #1;
            check($sformatf("streak_w%0d", c), 128'(sram_write), 128'(streak_exp[c]));
            check($sformatf("streak_r%0d", c), 128'(rd_req_ready), 128'(!streak_exp[c]));
            tick();
        end

        // Same-address read/write hazard on 0x10.
        wr_addr = 9'h010; wr_data = {16{8'h5A}};
        set_rd(1'b1, 9'h010, 4'd6);
        #1;
        check("hz_wr_gnt", 128'(wr_ready), 128'd1);
        check("hz_sram_wr", 128'(sram_write), 128'd1);
`ifdef SNITCH_ICACHE_DATA_CTRL_BYPASS_EN
        check("hz_rd_acc", 128'(rd_req_ready), 128'd1);
        tick();
        wr_valid = 1'b0;
        set_rd(1'b0, 9'h000, 4'd0);
        #1;
`else
        check("hz_rd_stall", 128'(rd_req_ready), 128'd0);
        tick();
        wr_valid = 1'b0;
        #1;
        check("hz_rd_gnt", 128'(rd_req_ready), 128'd1);
        tick();
        set_rd(1'b0, 9'h000, 4'd0);
        #1;
`endif
        check("hz_data", rd_rsp_data, {16{8'h5A}});
        check("hz_id", 128'(rd_rsp_id), 128'd6);
        tick();

        // Reset with one read in flight and one response buffered.
        rd_rsp_ready = 1'b0;
        set_rd(1'b1, 9'h007, 4'd5);
        tick();
        set_rd(1'b1, 9'h008, 4'd6);
        #1;
        check("mr_b_gnt", 128'(rd_req_ready), 128'd1);
        tick();
        set_rd(1'b1, 9'h009, 4'd7);
        #1;
        check("mr_pre_valid", 128'(rd_rsp_valid), 128'd1);
        rst_ni = 1'b0;
        #1;
        check("mr_rsp_valid", 128'(rd_rsp_valid), 128'd0);
        check("mr_rsp_data", rd_rsp_data, 128'd0);
        check("mr_rsp_id", 128'(rd_rsp_id), 128'd0);
        check("mr_rd_ready", 128'(rd_req_ready), 128'd0);
        check("mr_sram_req", 128'(sram_req), 128'd0);
        check("mr_sram_addr", 128'(sram_addr), 128'd0);
        set_rd(1'b0, 9'h000, 4'd0);
        tick();
        tick();
        rst_ni = 1'b1;
        rd_rsp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("mr_post_valid%0d", c), 128'(rd_rsp_valid), 128'd0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
